// File: rtl/add16_mul_seq.sv
// Sequential 16x16 -> low-16 shift-and-add multiplier. Every accumulation goes
// through one shared Add16 adder, and each operation runs exactly 16 iterations.

module add16 (
  input  logic [15:0] i_x,
  input  logic [15:0] i_y,
  output logic [15:0] o_sum
);
  // Carry-out is intentionally dropped: the result is modulo 2^16.
  assign o_sum = i_x + i_y;
endmodule

module add16_mul_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  r_state;
  logic [15:0] r_mcand;
  logic [15:0] r_mplier;
  logic [15:0] r_acc;
  logic [15:0] r_product;
  // The iteration count is a thermometer code rather than a binary counter, so
  // no second adder is needed. Bit 14 is set after 15 iterations, which marks
  // the next edge as the 16th and final one.
  logic [14:0] r_count;

  logic [15:0] w_sum;
  logic [15:0] w_acc_next;
  logic        w_last;

  add16 u_add16 (
    .i_x   (r_acc),
    .i_y   (r_mcand),
    .o_sum (w_sum)
  );

  assign w_acc_next = r_mplier[0] ? w_sum : r_acc;
  assign w_last     = r_count[14];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_mcand   <= 16'h0000;
      r_mplier  <= 16'h0000;
      r_acc     <= 16'h0000;
      r_count   <= 15'h0000;
      r_product <= 16'h0000;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_mcand  <= a;
            r_mplier <= b;
            r_acc    <= 16'h0000;
            r_count  <= 15'h0000;
            r_state  <= ST_RUN;
          end else begin
            r_state  <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_acc    <= w_acc_next;
          r_mcand  <= {r_mcand[14:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[15:1]};
          r_count  <= {r_count[13:0], 1'b1};
          if (w_last) begin
            r_product <= w_acc_next;
            r_state   <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy    = (r_state == ST_RUN);
  assign done    = (r_state == ST_DONE);
  assign product = r_product;

endmodule

// File: tb/tb_add16_mul_seq.sv
// Self-checking bench for add16_mul_seq: vector table plus hand-written corner
// sequences, with a product scoreboard that is checked on every done pulse.

module tb_add16_mul_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int checks = 0;
  int errors = 0;
  logic [15:0] sb[$];
  logic [15:0] last_prod = 16'h0000;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[10];

  add16_mul_seq dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    logic [15:0] exp_v;
    if (!reset && done) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got product 0x%04h expected no done", product);
      end else begin
        exp_v = sb.pop_front();
        if (product !== exp_v) begin
          errors++;
          $display("FAIL product: got 0x%04h expected 0x%04h", product, exp_v);
        end
      end
    end
  end

  // One full operation; optionally re-pulses start (7*7) while RUN is active.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic [15:0] exp, input int repulse_at);
    int lat;
    int busy_n;
    bit got;
    @(negedge clk);
    start = 1'b1;
    a = ta;
    b = tb_v;
    sb.push_back(exp);
    @(negedge clk);
    start = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    lat = 0;
    busy_n = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      if (done) begin
        got = 1'b1;
      end else begin
        if (busy) busy_n++;
        chk("product_hold", {16'h0, product}, {16'h0, last_prod});
        if (lat == repulse_at) begin
          start = 1'b1;
          a = 16'h0007;
          b = 16'h0007;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
        lat++;
      end
    end
    start = 1'b0;
    chk("done_seen", {31'h0, got}, 32'h1);
    chk("latency", lat, 16);
    chk("busy_cycles", busy_n, 16);
    chk("busy_in_done", {31'h0, busy}, 32'h0);
    $display("op a=0x%04h b=0x%04h product=0x%04h expected=0x%04h latency=%0d",
             ta, tb_v, product, exp, lat);
    last_prod = exp;
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    int since;
    int ndone;

    vecs[0] = '{16'h0003, 16'h0005, 16'h000F};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 16'h0001};
    vecs[2] = '{16'h0100, 16'h0100, 16'h0000};
    vecs[3] = '{16'h1234, 16'h0000, 16'h0000};
    vecs[4] = '{16'h0000, 16'h1234, 16'h0000};
    vecs[5] = '{16'h8000, 16'h0002, 16'h0000};
    vecs[6] = '{16'hFFFF, 16'h0002, 16'hFFFE};
    vecs[7] = '{16'h1234, 16'h5678, 16'h0060};
    vecs[8] = '{16'hFFFF, 16'h0003, 16'hFFFD};
    vecs[9] = '{16'h00FF, 16'h00FF, 16'hFE01};

    reset = 1'b1;
    start = 1'b0;
    a = 16'h0;
    b = 16'h0;
    #12;
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_done", {31'h0, done}, 32'h0);
    chk("reset_product", {16'h0, product}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].exp, -1);

    for (int i = 0; i < 4; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      run_op(ra, rb, ra * rb, -1);
    end

    // start re-pulsed mid-RUN must be ignored
    run_op(16'h0003, 16'h0005, 16'h000F, 4);
    repeat (20) begin
      @(negedge clk);
      chk("no_second_run", {30'h0, busy, done}, 32'h0);
    end

    // asynchronous reset in the middle of an operation
    @(negedge clk);
    start = 1'b1;
    a = 16'h0003;
    b = 16'h0005;
    sb.push_back(16'h000F);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("busy_before_abort", {31'h0, busy}, 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_done", {31'h0, done}, 32'h0);
    chk("abort_product", {16'h0, product}, 32'h0);
    sb.delete();
    $display("op abort a=0x0003 b=0x0005 product=0x%04h expected=0x0000", product);
    @(negedge clk);
    reset = 1'b0;
    last_prod = 16'h0000;
    repeat (20) begin
      @(negedge clk);
      chk("no_done_after_abort", {30'h0, busy, done}, 32'h0);
    end
    run_op(16'h0006, 16'h0007, 16'h002A, -1);

    // start held high: back-to-back operations, done every 17 cycles
    @(negedge clk);
    start = 1'b1;
    a = 16'h0002;
    b = 16'h0003;
    sb.push_back(16'h0006);
    sb.push_back(16'h0006);
    sb.push_back(16'h0006);
    since = 0;
    ndone = 0;
    for (int cyc = 0; cyc < 80 && ndone < 3; cyc++) begin
      @(negedge clk);
      since++;
      chk("busy_xor_done", {31'h0, busy ^ done}, 32'h1);
      if (done) begin
        ndone++;
        if (ndone > 1) chk("b2b_period", since, 17);
        $display("op b2b a=0x0002 b=0x0003 product=0x%04h expected=0x0006 period=%0d",
                 product, since);
        since = 0;
      end
    end
    start = 1'b0;
    chk("b2b_count", ndone, 3);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/add16_mul_seq.md
ADD16_MUL_SEQ -- requirements
Module: add16_mul_seq

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset; forces reset state immediately, independent of clk.
REQ-003 start  input  1  request to begin a multiply; sampled on rising clk.
REQ-004 a  input  16  multiplicand; captured on an accepted start.
REQ-005 b  input  16  multiplier; captured on an accepted start.
REQ-006 busy  output  1  high while an operation is in progress (RUN state).
REQ-007 done  output  1  one-cycle pulse: product holds a new result.
REQ-008 product  output  16  low 16 bits of a*b, registered.

Function
REQ-009 The block SHALL compute product = (a*b) mod 2^16, unsigned; two's-complement operands yield the correct low 16 bits.
REQ-010 All additions SHALL use one shared Add16 instance (sum = x + y mod 2^16, carry discarded); no other adder or '*' operator.
REQ-011 States: IDLE, RUN, DONE; reset enters IDLE.
REQ-012 IDLE: start=1 at edge k -> capture mcand<=a, mplier<=b, acc<=0, count<=0, enter RUN; start=0 -> stay IDLE.
REQ-013 RUN, each edge: if mplier[0]=1 then acc<=Add16(acc,mcand), else acc holds; mcand<=mcand<<1; mplier<=mplier>>1; count<=count+1.
REQ-014 RUN SHALL execute exactly 16 iterations (edges k+1..k+16) regardless of operand values; no early exit.
REQ-015 On the 16th RUN edge (k+16): product<=final acc value (including that iteration's add), enter DONE.
REQ-016 busy SHALL be 1 exactly while in RUN (after edge k through edge k+16), else 0.
REQ-017 done SHALL be 1 exactly while in DONE (one cycle, after edge k+16), else 0.
REQ-018 DONE: start=1 -> accepted as in IDLE (back-to-back, next RUN begins); start=0 -> IDLE.
REQ-019 start while in RUN SHALL be ignored; a, b, and in-flight state unaffected.
REQ-020 a and b SHALL be don't-care except on the accepting edge.
REQ-021 product SHALL hold its last value until next DONE entry; it does not change during RUN.
REQ-022 Add16 carry-out is dropped every iteration; mcand bits shifted past bit 15 are lost.

Reset
REQ-023 reset=1 SHALL asynchronously force state=IDLE, busy=0, done=0, product=0x0000, acc=0, mcand=0, mplier=0, count=0.
REQ-024 reset asserted mid-RUN SHALL abort the operation; no done pulse for it; product=0x0000.
REQ-025 After reset deasserts, first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-026 a=3, b=5, start one cycle -> busy high 16 cycles, done pulse at edge k+16, product=0x000F.
REQ-027 a=0xFFFF, b=0xFFFF -> product=0x0001; a=0x0100, b=0x0100 -> product=0x0000 (wrap).
REQ-028 a=0x1234, b=0x0000 -> product=0x0000 after full 16-cycle latency; done still pulses once.
REQ-029 start re-pulsed with a=7, b=7 at edge k+5 of a 3*5 op -> ignored; product=0x000F, single done.
REQ-030 reset pulse at edge k+8 of 3*5 -> busy/done/product 0 immediately, no done; new 6*7 after release -> product=0x002A.
REQ-031 start held high continuously with a=2,b=3 -> done every 17 cycles, product=0x0006 each time, busy low only during DONE.
